// File: rtl/binary_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// result presented with a single-cycle out_valid pulse after WIDTH iterations.
module binary_to_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      Bin,
    output logic                  busy,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   bin_sr;
    logic [BW-1:0]      scratch;
    logic [BW-1:0]      adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [CW-1:0]      cnt;
    logic               done;

    // Add-3 correction on every scratch digit >= 5, then shift the whole chain left.
    always_comb begin
        adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_sr} << 1;
    end

    assign done = (state == RUN) && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (done)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr    <= '0;
            scratch   <= '0;
            cnt       <= '0;
            BCD       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr  <= Bin;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    scratch <= shifted[BW+WIDTH-1:WIDTH];
                    bin_sr  <= shifted[WIDTH-1:0];
                    cnt     <= cnt - 1'b1;
                    if (done) begin
                        BCD       <= shifted[BW+WIDTH-1:WIDTH];
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd: stimulus pushes expected BCD and accept
// cycle; a negedge monitor pops on out_valid and checks value, latency and hold.
module tb_binary_to_bcd;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  Bin = '0;
    logic        busy;
    logic        out_valid;
    logic [11:0] BCD;

    binary_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Bin       (Bin),
        .busy      (busy),
        .out_valid (out_valid),
        .BCD       (BCD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] exp;
        int unsigned acc;
    } item_t;

    item_t       sbq[$];
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [11:0] hold_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [11:0] ref_bcd(input int unsigned v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: results only on out_valid; otherwise BCD must hold the last result.
    item_t it;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    it = sbq.pop_front();
                    check("bcd", 32'(BCD), 32'(it.exp));
                    check("latency", cyc - it.acc, WIDTH);
                    hold_exp = it.exp;
                end
            end else begin
                check("bcd_hold", 32'(BCD), 32'(hold_exp));
            end
        end
    end

    task automatic wait_accept(input logic [11:0] exp, output int unsigned acc);
        bit ok;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy) begin
                @(posedge clk);
                #1;
                sbq.push_back('{exp, cyc});
                acc = cyc;
                ok  = 1'b1;
            end
        end
        if (!ok) check("accept_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [7:0] v, input logic [11:0] exp);
        int unsigned a;
        in_valid = 1'b1;
        Bin      = v;
        wait_accept(exp, a);
        in_valid = 1'b0;
        Bin      = ~v;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check("sb_drain", sbq.size(), 32'd0);
    endtask

    task automatic async_reset_check(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_bcd"}, 32'(BCD), 32'd0);
        sbq.delete();
        hold_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0]  sv [12];
    logic [11:0] se [12];
    int unsigned a1, a2;

    initial begin
        sv = '{8'd0, 8'd5, 8'd9, 8'd10, 8'd42, 8'd85, 8'd99, 8'd100, 8'd128, 8'd173, 8'd200, 8'd255};
        se = '{12'h000, 12'h005, 12'h009, 12'h010, 12'h042, 12'h085, 12'h099, 12'h100,
               12'h128, 12'h173, 12'h200, 12'h255};

        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(BCD), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue(sv[i], se[i]);
        end
        drain();

        // A second request mid-conversion must be dropped.
        issue(8'd42, 12'h042);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        Bin      = 8'd99;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        repeat (12) @(posedge clk);
        #1;

        // Held in_valid: next request taken on the edge right after completion.
        in_valid = 1'b1;
        Bin      = 8'd173;
        wait_accept(12'h173, a1);
        Bin = 8'd85;
        wait_accept(12'h085, a2);
        in_valid = 1'b0;
        check("b2b_gap", a2 - a1, WIDTH + 1);
        drain();

        // Abort a conversion of 200 with an asynchronous mid-cycle reset.
        issue(8'd200, 12'h200);
        repeat (3) @(posedge clk);
        async_reset_check("abort");
        repeat (12) @(posedge clk);
        #1;
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_bcd", 32'(BCD), 32'd0);
        issue(8'd200, 12'h200);
        drain();

        for (int v = 0; v < 256; v++) begin
            issue(8'(v), ref_bcd(v));
        end
        drain();
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
